pe_tile_param: RTL and testbench

Parametrised successor of the fixed bottom-left PE tile. A single routing and compute tile with four sides (0..3), TRACKS tracks per side and WIDTH bits per track. It contains its own configuration register file, addressed by tile_id and register index, with write and readback. The datapath has two connect boxes, a bitwise 2-input LUT PE with an optional output register, and a fully configurable switch box on all four sides.

---
 rtl/pe_tile_param.sv | 135 +++++++++++++
 tb/tb_pe_tile_param.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_tile_param.sv
// Parametrised routing/compute tile: config register file, two connect boxes,
// a bitwise 2-input LUT PE with optional output register, and a four-side switch box.
module pe_tile_param #(
  parameter int TRACKS = 4,
  parameter int WIDTH  = 1,
  parameter int SEL_W  = $clog2(2*TRACKS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 config_addr,
  input  logic [31:0]                 config_data,
  input  logic                        config_wr,
  input  logic                        config_rd,
  input  logic [15:0]                 tile_id,
  output logic [31:0]                 config_rd_data,
  output logic                        config_rd_valid,
  input  logic [4*TRACKS*WIDTH-1:0]   in_wires,
  output logic [4*TRACKS*WIDTH-1:0]   out_wires,
  output logic [WIDTH-1:0]            pe_out
);

  logic                  hit;
  logic [15:0]           cfg_idx;
  logic [SEL_W-1:0]      cb0_sel;
  logic [SEL_W-1:0]      cb1_sel;
  logic [3:0]            pe_lut;
  logic                  pe_reg_en;
  logic [2*TRACKS-1:0]   sb_cfg [4];
  logic [31:0]           rd_mux;

  logic [WIDTH-1:0]      in_w [4][TRACKS];
  logic [WIDTH-1:0]      op0;
  logic [WIDTH-1:0]      op1;
  logic [WIDTH-1:0]      pe_f;
  logic [WIDTH-1:0]      pe_reg;

  assign hit     = (config_addr[15:0] == tile_id);
  assign cfg_idx = config_addr[31:16];

  // Register file write port; unmapped indices and misses are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      cb0_sel   <= '0;
      cb1_sel   <= '0;
      pe_lut    <= '0;
      pe_reg_en <= 1'b0;
      for (int s = 0; s < 4; s++) sb_cfg[s] <= '0;
    end else if (config_wr && hit) begin
      case (cfg_idx)
        16'd0: cb0_sel <= config_data[SEL_W-1:0];
        16'd1: cb1_sel <= config_data[SEL_W-1:0];
        16'd2: begin
          pe_lut    <= config_data[3:0];
          pe_reg_en <= config_data[4];
        end
        16'd3: sb_cfg[0] <= config_data[2*TRACKS-1:0];
        16'd4: sb_cfg[1] <= config_data[2*TRACKS-1:0];
        16'd5: sb_cfg[2] <= config_data[2*TRACKS-1:0];
        16'd6: sb_cfg[3] <= config_data[2*TRACKS-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (cfg_idx)
      16'd0: rd_mux = 32'(cb0_sel);
      16'd1: rd_mux = 32'(cb1_sel);
      16'd2: rd_mux = {27'd0, pe_reg_en, pe_lut};
      16'd3: rd_mux = 32'(sb_cfg[0]);
      16'd4: rd_mux = 32'(sb_cfg[1]);
      16'd5: rd_mux = 32'(sb_cfg[2]);
      16'd6: rd_mux = 32'(sb_cfg[3]);
      default: rd_mux = '0;
    endcase
  end

  // Readback samples the pre-write register value when read and write collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      config_rd_valid <= 1'b0;
      config_rd_data  <= '0;
    end else begin
      config_rd_valid <= config_rd && hit;
      config_rd_data  <= (config_rd && hit) ? rd_mux : '0;
    end
  end

  for (genvar s = 0; s < 4; s++) begin : g_unpack_side
    for (genvar t = 0; t < TRACKS; t++) begin : g_unpack_track
      assign in_w[s][t] = in_wires[(s*TRACKS+t)*WIDTH +: WIDTH];
    end
  end

  // Select codes at or above 2*TRACKS (possible when TRACKS is not a power of 2) yield 0.
  always_comb begin
    op0 = '0;
    op1 = '0;
    for (int t = 0; t < TRACKS; t++) begin
      if (cb0_sel == SEL_W'(t))          op0 = in_w[0][t];
      if (cb0_sel == SEL_W'(t + TRACKS)) op0 = in_w[1][t];
      if (cb1_sel == SEL_W'(t))          op1 = in_w[2][t];
      if (cb1_sel == SEL_W'(t + TRACKS)) op1 = in_w[3][t];
    end
  end

  always_comb begin
    pe_f = '0;
    for (int i = 0; i < WIDTH; i++) pe_f[i] = pe_lut[{op1[i], op0[i]}];
  end

  // Loads every cycle so flipping reg_en never exposes data older than one cycle.
  always_ff @(posedge clk) begin
    if (reset) pe_reg <= '0;
    else       pe_reg <= pe_f;
  end

  assign pe_out = pe_reg_en ? pe_reg : pe_f;

  for (genvar s = 0; s < 4; s++) begin : g_sb_side
    localparam int S0 = (s == 0) ? 1 : 0;
    localparam int S1 = (s <= 1) ? 2 : 1;
    localparam int S2 = (s <= 2) ? 3 : 2;
    for (genvar t = 0; t < TRACKS; t++) begin : g_sb_track
      logic [1:0] code;
      assign code = sb_cfg[s][2*t +: 2];
      assign out_wires[(s*TRACKS+t)*WIDTH +: WIDTH] =
        (code == 2'd3) ? pe_out :
        (code == 2'd2) ? in_w[S2][t] :
        (code == 2'd1) ? in_w[S1][t] : in_w[S0][t];
    end
  end

endmodule

// File: tb/tb_pe_tile_param.sv
// Self-checking bench for pe_tile_param (TRACKS=4, WIDTH=1, tile_id=5) with a
// behavioural model of the register map, connect boxes, LUT and switch box.
module tb_pe_tile_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_wr;
  logic        config_rd;
  logic [15:0] tile_id;
  logic [31:0] config_rd_data;
  logic        config_rd_valid;
  logic [15:0] in_wires;
  logic [15:0] out_wires;
  logic [0:0]  pe_out;

  int checks = 0;
  int passes = 0;
  logic [31:0] mdl_reg [16];

  pe_tile_param #(.TRACKS(4), .WIDTH(1)) dut (
    .clk(clk), .reset(reset),
    .config_addr(config_addr), .config_data(config_data),
    .config_wr(config_wr), .config_rd(config_rd), .tile_id(tile_id),
    .config_rd_data(config_rd_data), .config_rd_valid(config_rd_valid),
    .in_wires(in_wires), .out_wires(out_wires), .pe_out(pe_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] reg_mask(input int idx);
    if (idx <= 1) return 32'h7;
    if (idx == 2) return 32'h1F;
    if (idx <= 6) return 32'hFF;
    return 32'h0;
  endfunction

  // LUT output from the model's connect-box selects: sel/4 picks the side, sel%4 the track.
  function automatic logic exp_f(input logic [15:0] iw);
    int sel0, sel1;
    logic a, b;
    logic [3:0] lut;
    sel0 = int'(mdl_reg[0][2:0]);
    sel1 = int'(mdl_reg[1][2:0]);
    a = iw[(sel0 / 4) * 4 + (sel0 % 4)];
    b = iw[(2 + sel1 / 4) * 4 + (sel1 % 4)];
    lut = mdl_reg[2][3:0];
    return lut[{b, a}];
  endfunction

  function automatic logic [15:0] exp_out(input logic [15:0] iw, input logic pe);
    logic [15:0] e;
    int code, k;
    e = '0;
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < 4; t++) begin
        code = int'((mdl_reg[3+s] >> (2*t)) & 32'h3);
        if (code == 3) e[s*4+t] = pe;
        else begin
          k = 0;
          for (int o = 0; o < 4; o++) begin
            if (o != s) begin
              if (k == code) e[s*4+t] = iw[o*4+t];
              k++;
            end
          end
        end
      end
    end
    return e;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    int idx;
    @(negedge clk);
    config_addr = addr;
    config_data = data;
    config_wr   = 1'b1;
    @(negedge clk);
    config_wr = 1'b0;
    idx = int'(addr[31:16]);
    if (addr[15:0] == 16'h0005 && idx < 16) mdl_reg[idx] = data & reg_mask(idx);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic v, output logic [31:0] d);
    @(negedge clk);
    config_addr = addr;
    config_rd   = 1'b1;
    @(negedge clk);
    config_rd = 1'b0;
    v = config_rd_valid;
    d = config_rd_data;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mdl_reg[i] = '0;
  endtask

  task automatic test_reset();
    logic v;
    logic [31:0] d;
    apply_reset();
    checks++;
    if (config_rd_valid !== 1'b0 || config_rd_data !== 32'h0)
      $display("FAIL reset_rd_outputs got valid=%b data=%h exp 0/0", config_rd_valid, config_rd_data);
    else passes++;
    do_read(32'h0002_0005, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) $display("FAIL reset_read_idx2 got valid=%b data=%h exp 1/0", v, d);
    else passes++;
    in_wires = 16'($urandom);
    #1;
    checks++;
    if (out_wires !== {in_wires[3:0], in_wires[3:0], in_wires[3:0], in_wires[7:4]})
      $display("FAIL reset_sb_default got %h in %h", out_wires, in_wires);
    else passes++;
    checks++;
    if (pe_out !== 1'b0) $display("FAIL reset_pe_out got %b exp 0", pe_out);
    else passes++;
  endtask

  task automatic test_comb_and();
    do_write(32'h0000_0005, 32'd5);
    do_write(32'h0001_0005, 32'd2);
    do_write(32'h0002_0005, 32'h8);
    in_wires = 16'h0420;
    #1;
    checks++;
    if (pe_out !== 1'b1) $display("FAIL comb_and_both got %b exp 1", pe_out);
    else passes++;
    in_wires = 16'h0400;
    #1;
    checks++;
    if (pe_out !== 1'b0) $display("FAIL comb_and_drop_op0 got %b exp 0", pe_out);
    else passes++;
    in_wires = 16'h0020;
    #1;
    checks++;
    if (pe_out !== 1'b0) $display("FAIL comb_and_drop_op1 got %b exp 0", pe_out);
    else passes++;
  endtask

  task automatic test_registered();
    do_write(32'h0002_0005, 32'h18);
    do_write(32'h0003_0005, 32'h0000_00C0);
    in_wires = 16'h0000;
    repeat (2) @(negedge clk);
    in_wires = 16'h0420;
    #1;
    checks++;
    if (pe_out !== 1'b0 || out_wires[3] !== 1'b0)
      $display("FAIL reg_before_edge got pe=%b out3=%b exp 0/0", pe_out, out_wires[3]);
    else passes++;
    @(negedge clk);
    checks++;
    if (pe_out !== 1'b1 || out_wires[3] !== 1'b1)
      $display("FAIL reg_after_edge got pe=%b out3=%b exp 1/1", pe_out, out_wires[3]);
    else passes++;
    in_wires = 16'h0000;
    #1;
    checks++;
    if (pe_out !== 1'b1) $display("FAIL reg_hold got %b exp 1", pe_out);
    else passes++;
    @(negedge clk);
    checks++;
    if (pe_out !== 1'b0) $display("FAIL reg_fall got %b exp 0", pe_out);
    else passes++;
  endtask

  task automatic test_addr_decode();
    logic v;
    logic [31:0] d;
    apply_reset();
    do_write(32'h0003_0006, 32'hFFFF_FFFF);
    do_read(32'h0003_0005, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) $display("FAIL wrong_tile_write got valid=%b data=%h exp 1/0", v, d);
    else passes++;
    do_write(32'h0009_0005, 32'hFFFF_FFFF);
    do_read(32'h0009_0005, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) $display("FAIL unmapped_read got valid=%b data=%h exp 1/0", v, d);
    else passes++;
    do_write(32'h0002_0005, 32'hFFFF_FFFF);
    do_read(32'h0002_0007, v, d);
    checks++;
    if (v !== 1'b0 || d !== 32'h0) $display("FAIL miss_read got valid=%b data=%h exp 0/0", v, d);
    else passes++;
    do_read(32'h0002_0005, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'h1F) $display("FAIL pe_cfg_mask got valid=%b data=%h exp 1/1f", v, d);
    else passes++;
  endtask

  task automatic test_rw_collision();
    logic v;
    logic [31:0] d;
    do_write(32'h0000_0005, 32'd5);
    @(negedge clk);
    config_addr = 32'h0000_0005;
    config_data = 32'd3;
    config_wr   = 1'b1;
    config_rd   = 1'b1;
    @(negedge clk);
    config_wr = 1'b0;
    config_rd = 1'b0;
    mdl_reg[0] = 32'd3;
    checks++;
    if (config_rd_valid !== 1'b1 || config_rd_data !== 32'd5)
      $display("FAIL rw_same_cycle got valid=%b data=%h exp 1/5", config_rd_valid, config_rd_data);
    else passes++;
    do_read(32'h0000_0005, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'd3) $display("FAIL rw_followup got valid=%b data=%h exp 1/3", v, d);
    else passes++;
  endtask

  task automatic test_reset_during_write();
    logic v;
    logic [31:0] d;
    do_write(32'h0004_0005, 32'hFF);
    @(negedge clk);
    reset       = 1'b1;
    config_addr = 32'h0004_0005;
    config_data = 32'h55;
    config_wr   = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    config_wr = 1'b0;
    for (int i = 0; i < 16; i++) mdl_reg[i] = '0;
    do_read(32'h0004_0005, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) $display("FAIL reset_drops_write got valid=%b data=%h exp 1/0", v, d);
    else passes++;
    in_wires = 16'($urandom);
    #1;
    checks++;
    if (out_wires[4] !== in_wires[0])
      $display("FAIL reset_sb_side1 got %b exp %b", out_wires[4], in_wires[0]);
    else passes++;
  endtask

  task automatic test_random();
    logic v;
    logic [31:0] d;
    int ridx;
    logic f;
    for (int it = 0; it < 25; it++) begin
      for (int r = 0; r < 7; r++)
        if ($urandom_range(1, 0) == 1) do_write({16'(r), 16'h0005}, $urandom);
      ridx = $urandom_range(8, 0);
      do_read({16'(ridx), 16'h0005}, v, d);
      checks++;
      if (v !== 1'b1 || d !== mdl_reg[ridx])
        $display("FAIL rand_readback idx=%0d got valid=%b data=%h exp 1/%h", ridx, v, d, mdl_reg[ridx]);
      else passes++;
      in_wires = 16'($urandom);
      f = exp_f(in_wires);
      #1;
      if (mdl_reg[2][4] == 1'b0) begin
        checks++;
        if (pe_out !== f) $display("FAIL rand_comb_pe got %b exp %b in %h", pe_out, f, in_wires);
        else passes++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (pe_out !== f) $display("FAIL rand_pe got %b exp %b in %h", pe_out, f, in_wires);
      else passes++;
      checks++;
      if (out_wires !== exp_out(in_wires, f))
        $display("FAIL rand_sb got %h exp %h in %h", out_wires, exp_out(in_wires, f), in_wires);
      else passes++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    config_addr = '0;
    config_data = '0;
    config_wr   = 1'b0;
    config_rd   = 1'b0;
    tile_id     = 16'h0005;
    in_wires    = '0;
    for (int i = 0; i < 16; i++) mdl_reg[i] = '0;
    test_reset();
    test_comb_and();
    test_registered();
    test_addr_decode();
    test_rw_collision();
    test_reset_during_write();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
